// File: rtl/vga_pkg.sv
// Shared types and default geometry for the VGA framebuffer fetch scheduler.
package vga_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DONE  = 2'd2,
    DRAIN = 2'd3
  } state_t;

  localparam int VGA_HDISP      = 800;
  localparam int VGA_VDISP      = 480;
  localparam int BYTES_PER_WORD = 4;

endpackage

// File: rtl/vga_credit_cnt.sv
// In-flight word credit counter: +BURST per accepted request, -1 per FIFO write, floors at zero.
module vga_credit_cnt #(
  parameter int BURST = 16,
  parameter int W     = 9
) (
  input  logic         pixel_clk,
  input  logic         pixel_rst,
  input  logic         add,
  input  logic         sub,
  output logic [W-1:0] count,
  output logic [W-1:0] count_next
);

  localparam logic [W-1:0] BURST_W = W'(BURST);
  localparam logic [W-1:0] ONE_W   = W'(1);

  always_comb begin
    count_next = count;
    case ({add, sub})
      2'b10:   count_next = count + BURST_W;
      2'b11:   count_next = count + BURST_W - ONE_W;
      // A write with nothing outstanding is treated as spurious.
      2'b01:   count_next = (count == '0) ? '0 : count - ONE_W;
      default: count_next = count;
    endcase
  end

  always_ff @(posedge pixel_clk or posedge pixel_rst) begin
    if (pixel_rst) count <= '0;
    else           count <= count_next;
  end

endmodule

// File: rtl/vga_fetch_sched.sv
// Issues burst reads that keep the pixel FIFO topped up for one frame,
// restarting cleanly when a new frame begins before the old one is fully requested.
module vga_fetch_sched
  import vga_pkg::*;
#(
  parameter int HDISP      = VGA_HDISP,
  parameter int VDISP      = VGA_VDISP,
  parameter int BURST      = 16,
  parameter int FIFO_DEPTH = 256,
  parameter int AW         = 32
) (
  input  logic                          pixel_clk,
  input  logic                          pixel_rst,
  input  logic                          enable,
  input  logic                          frame_start,
  input  logic [AW-1:0]                 base_addr,
  input  logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  input  logic                          wr_valid,
  output logic                          rd_req,
  output logic [AW-1:0]                 rd_addr,
  input  logic                          rd_ack,
  output logic                          fifo_flush,
  output logic                          busy,
  output logic                          late
);

  localparam int LW    = $clog2(FIFO_DEPTH) + 1;
  localparam int TOTAL = HDISP * VDISP;
  localparam int WCW   = $clog2(TOTAL + 1);
  localparam int TW    = LW + 2;
  localparam logic [WCW-1:0] TOTAL_W  = WCW'(TOTAL);
  localparam logic [WCW-1:0] BURST_WC = WCW'(BURST);

  state_t          state_reg, state_next;
  logic [WCW-1:0]  word_cnt_reg, word_next;
  logic [AW-1:0]   base_reg, base_next;
  logic [LW-1:0]   inflight, inflight_next;
  logic [TW-1:0]   demand;
  logic            room;
  logic            accept;
  logic            rd_req_next, flush_next, busy_next, late_next;
  logic [AW-1:0]   rd_addr_next;

  assign accept = rd_req & rd_ack;

  vga_credit_cnt #(
    .BURST (BURST),
    .W     (LW)
  ) u_credit (
    .pixel_clk  (pixel_clk),
    .pixel_rst  (pixel_rst),
    .add        (accept),
    .sub        (wr_valid),
    .count      (inflight),
    .count_next (inflight_next)
  );

  always_comb begin
    state_next = state_reg;
    word_next  = word_cnt_reg;
    base_next  = base_reg;
    flush_next = 1'b0;
    late_next  = late;

    case (state_reg)
      IDLE, DONE: begin
        if (frame_start) begin
          if (enable) begin
            state_next = FETCH;
            base_next  = base_addr;
            word_next  = '0;
            flush_next = 1'b1;
          end else begin
            state_next = IDLE;
          end
        end
      end
      FETCH: begin
        if (frame_start) begin
          late_next  = 1'b1;
          state_next = DRAIN;
        end else if (accept) begin
          word_next = word_cnt_reg + BURST_WC;
          if (word_next == TOTAL_W) state_next = DONE;
        end
      end
      DRAIN: begin
        // Restart only once every requested word has landed, so the flush is clean.
        if (inflight == '0) begin
          flush_next = 1'b1;
          base_next  = base_addr;
          word_next  = '0;
          state_next = enable ? FETCH : IDLE;
        end
      end
      default: state_next = IDLE;
    endcase

    // Headroom bits keep level + credits + burst from wrapping.
    demand = TW'(fifo_level) + TW'(inflight_next) + TW'(BURST);
    room   = (demand <= TW'(FIFO_DEPTH));

    if (rd_req && !rd_ack && (state_next == FETCH))
      rd_req_next = 1'b1;
    else
      rd_req_next = (state_next == FETCH) && (word_next < TOTAL_W) && room;

    rd_addr_next = base_next + AW'(word_next) * AW'(BYTES_PER_WORD);
    busy_next    = (state_next == FETCH) || (state_next == DRAIN);
  end

  always_ff @(posedge pixel_clk or posedge pixel_rst) begin
    if (pixel_rst) begin
      state_reg    <= IDLE;
      word_cnt_reg <= '0;
      base_reg     <= '0;
      rd_req       <= 1'b0;
      rd_addr      <= '0;
      fifo_flush   <= 1'b0;
      busy         <= 1'b0;
      late         <= 1'b0;
    end else begin
      state_reg    <= state_next;
      word_cnt_reg <= word_next;
      base_reg     <= base_next;
      rd_req       <= rd_req_next;
      rd_addr      <= rd_addr_next;
      fifo_flush   <= flush_next;
      busy         <= busy_next;
      late         <= late_next;
    end
  end

endmodule

// File: tb/tb_vga_fetch_sched.sv
// Directed bench for vga_fetch_sched: burst addresses scoreboarded, state/flags checked inline.
module tb_vga_fetch_sched;

  localparam int HDISP      = 8;
  localparam int VDISP      = 2;
  localparam int BURST      = 4;
  localparam int FIFO_DEPTH = 16;
  localparam int AW         = 32;
  localparam int LW         = $clog2(FIFO_DEPTH) + 1;

  logic          pixel_clk = 1'b0;
  logic          pixel_rst = 1'b1;
  logic          enable = 1'b0;
  logic          frame_start = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [LW-1:0] fifo_level = '0;
  logic          wr_valid = 1'b0;
  logic          rd_ack = 1'b0;
  logic          rd_req;
  logic [AW-1:0] rd_addr;
  logic          fifo_flush;
  logic          busy;
  logic          late;

  int            tests = 0;
  int            fails = 0;
  int            flush_cnt = 0;
  int            hs_cnt = 0;
  logic [AW-1:0] exp_q[$];

  vga_fetch_sched #(
    .HDISP      (HDISP),
    .VDISP      (VDISP),
    .BURST      (BURST),
    .FIFO_DEPTH (FIFO_DEPTH),
    .AW         (AW)
  ) dut (
    .pixel_clk   (pixel_clk),
    .pixel_rst   (pixel_rst),
    .enable      (enable),
    .frame_start (frame_start),
    .base_addr   (base_addr),
    .fifo_level  (fifo_level),
    .wr_valid    (wr_valid),
    .rd_req      (rd_req),
    .rd_addr     (rd_addr),
    .rd_ack      (rd_ack),
    .fifo_flush  (fifo_flush),
    .busy        (busy),
    .late        (late)
  );

  always #5 pixel_clk = ~pixel_clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge pixel_clk);
    #1;
  endtask

  // Each handshake seen pops the next expected burst address.
  task automatic run_cycles(input int n);
    logic [AW-1:0] exp_addr;
    for (int i = 0; i < n; i++) begin
      if (fifo_flush) flush_cnt++;
      if (rd_req && rd_ack) begin
        hs_cnt++;
        exp_addr = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
        $display("[TB] burst addr=%08h expected=%08h", rd_addr, exp_addr);
        check("burst_addr", rd_addr, exp_addr);
      end
      tick();
    end
  endtask

  initial begin
    // Reset state
    tick(); tick(); tick();
    check("rst_rd_req", rd_req, 0);
    check("rst_rd_addr", rd_addr, 0);
    check("rst_flush", fifo_flush, 0);
    check("rst_busy", busy, 0);
    check("rst_late", late, 0);
    pixel_rst = 1'b0;
    tick();

    // Full frame with immediate acks and an empty FIFO
    base_addr = 32'h1000; enable = 1'b1; fifo_level = '0; rd_ack = 1'b1;
    exp_q.push_back(32'h1000); exp_q.push_back(32'h1010);
    exp_q.push_back(32'h1020); exp_q.push_back(32'h1030);
    flush_cnt = 0; hs_cnt = 0;
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    run_cycles(8);
    check("f1_bursts", hs_cnt, 4);
    check("f1_queue_left", exp_q.size(), 0);
    check("f1_flushes", flush_cnt, 1);
    check("f1_done_rd_req", rd_req, 0);
    check("f1_done_busy", busy, 0);
    check("f1_inflight", dut.inflight, 16);
    rd_ack = 1'b0; wr_valid = 1'b1;
    for (int i = 0; i < 17; i++) tick();   // one extra write beyond the credits
    wr_valid = 1'b0;
    check("f1_inflight_floor", dut.inflight, 0);

    // Threshold gating and held request
    fifo_level = 12;
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    check("f2_flush", fifo_flush, 1);
    for (int i = 0; i < 5; i++) begin
      check("hold_rd_req", rd_req, 1);
      check("hold_rd_addr", rd_addr, 32'h1000);
      tick();
    end
    exp_q.push_back(32'h1000);
    hs_cnt = 0;
    rd_ack = 1'b1;
    run_cycles(1);
    rd_ack = 1'b0;
    check("f2_hs", hs_cnt, 1);
    check("f2_inflight", dut.inflight, 4);
    check("f2_gated", rd_req, 0);
    tick();
    check("f2_gated2", rd_req, 0);
    fifo_level = 9;
    tick(); tick();
    check("f2_above_thresh", rd_req, 0);
    fifo_level = 8;
    tick();
    check("f2_thresh_req", rd_req, 1);
    check("f2_thresh_addr", rd_addr, 32'h1010);
    exp_q.push_back(32'h1010);
    rd_ack = 1'b1;
    run_cycles(1);
    rd_ack = 1'b0;
    check("f2_inflight8", dut.inflight, 8);

    // Late frame_start: drain then restart at the new base
    base_addr = 32'h2000;
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    fifo_level = '0;
    check("late_set", late, 1);
    check("drain_busy", busy, 1);
    check("drain_no_req", rd_req, 0);
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    check("drain_ignore_fs", fifo_flush, 0);
    wr_valid = 1'b1;
    for (int i = 0; i < 7; i++) tick();
    check("drain_busy2", busy, 1);
    check("drain_inflight1", dut.inflight, 1);
    tick();
    wr_valid = 1'b0;
    check("drain_no_flush_yet", fifo_flush, 0);
    tick();
    check("restart_flush", fifo_flush, 1);
    check("restart_req", rd_req, 1);
    check("restart_addr", rd_addr, 32'h2000);
    check("late_sticky", late, 1);

    // Ack and write in the same cycle
    exp_q.push_back(32'h2000);
    rd_ack = 1'b1;
    run_cycles(1);
    check("co_pre_inflight", dut.inflight, 4);
    exp_q.push_back(32'h2010);
    wr_valid = 1'b1;
    run_cycles(1);
    rd_ack = 1'b0; wr_valid = 1'b0;
    check("co_inflight7", dut.inflight, 7);

    // Asynchronous reset mid-fetch
    check("pre_rst_req", rd_req, 1);
    #2 pixel_rst = 1'b1;
    #1;
    check("arst_rd_req", rd_req, 0);
    check("arst_rd_addr", rd_addr, 0);
    check("arst_flush", fifo_flush, 0);
    check("arst_busy", busy, 0);
    check("arst_late", late, 0);
    check("arst_inflight", dut.inflight, 0);
    tick();
    pixel_rst = 1'b0;
    tick();
    enable = 1'b0;
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    check("dis_busy", busy, 0);
    check("dis_rd_req", rd_req, 0);
    check("dis_flush", fifo_flush, 0);
    tick(); tick(); tick();
    check("dis_busy2", busy, 0);
    check("dis_rd_req2", rd_req, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
